tone_voice_scheduler: RTL and testbench

//  Per-sample sequencer for the shared voice unit (phase accumulator + wavetable) inside the tone engine.
//  On each I2S frame pulse it walks the enabled voices in index order and requests one sample per voice.
//  It sums the signed samples, saturates the sum, and hands one mixed word to the I2S serializer (valid/ready).
//  It sits between the SPI-written voice config and the I2S output stage.

---
 rtl/tone_pkg.sv | 22 ++
 rtl/tone_sat_clamp.sv | 30 +++
 rtl/tone_voice_scheduler.sv | 141 ++++++++++++++
 tb/tb_tone_voice_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module : tone_pkg
// Brief  : Shared types and default sizes for the tone engine voice path.
// Rev    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    localparam int c_num_voices = 4;
    localparam int c_sample_w   = 16;
    localparam int c_acc_w      = c_sample_w + $clog2(c_num_voices);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_REQ  = 3'd2,
        ST_SAT  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tone_sat_clamp.sv
`default_nettype none
// ============================================================================
// Module : tone_sat_clamp
// Brief  : Combinational signed saturator from ACC_W down to SAMPLE_W bits.
// Rev    : 1.0 - initial release
// ============================================================================
module tone_sat_clamp #(
    parameter int ACC_W    = 18,
    parameter int SAMPLE_W = 16
) (
    input  logic signed [ACC_W-1:0]    acc_i,
    output logic        [SAMPLE_W-1:0] sat_o
);

    localparam logic signed [ACC_W-1:0] c_max =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_min =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    always_comb begin
        sat_o = acc_i[SAMPLE_W-1:0];
        if (acc_i > c_max) begin
            sat_o = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (acc_i < c_min) begin
            sat_o = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tone_voice_scheduler
// Brief  : Per-frame sequencer that walks enabled voices on the shared voice
//          unit, accumulates their samples and hands out one saturated mix.
// Rev    : 1.0 - initial release
// ============================================================================
module tone_voice_scheduler
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = c_num_voices,
    parameter int SAMPLE_W   = c_sample_w,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  frame_start_in,
    input  logic [NUM_VOICES-1:0] voice_en_in,
    output logic                  unit_req_out,
    output logic [VIDX_W-1:0]     unit_voice_out,
    input  logic                  unit_ack_in,
    input  logic [SAMPLE_W-1:0]   unit_sample_in,
    output logic                  mix_valid_out,
    output logic [SAMPLE_W-1:0]   mix_data_out,
    input  logic                  mix_ready_in,
    output logic                  busy_out,
    output logic                  overrun_out,
    input  logic                  clear_overrun_in
);

    localparam int                c_mix_acc_w = SAMPLE_W + VIDX_W;
    localparam logic [VIDX_W-1:0] c_last_idx  = VIDX_W'(NUM_VOICES - 1);

    state_t                        state_q;
    logic [NUM_VOICES-1:0]         mask_q;
    logic [VIDX_W-1:0]             idx_q;
    logic signed [c_mix_acc_w-1:0] acc_q;
    logic                          req_q;
    logic                          valid_q;
    logic                          busy_q;
    logic                          overrun_q;
    logic [SAMPLE_W-1:0]           mix_q;

    logic [SAMPLE_W-1:0]           w_sat;
    logic signed [c_mix_acc_w-1:0] w_sample_sext;
    logic                          w_last;

    assign w_sample_sext = {{VIDX_W{unit_sample_in[SAMPLE_W-1]}}, unit_sample_in};
    assign w_last        = (idx_q == c_last_idx);

    tone_sat_clamp #(
        .ACC_W    (c_mix_acc_w),
        .SAMPLE_W (SAMPLE_W)
    ) u_sat_clamp (
        .acc_i (acc_q),
        .sat_o (w_sat)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            mix_q     <= '0;
        end else begin
            // A frame pulse that cannot be served is dropped; flagging it beats a clear.
            if (frame_start_in && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun_in) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_start_in) begin
                        mask_q  <= voice_en_in;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (mask_q[idx_q]) begin
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end else if (w_last) begin
                        state_q <= ST_SAT;
                    end else begin
                        idx_q <= idx_q + VIDX_W'(1);
                    end
                end
                ST_REQ: begin
                    if (unit_ack_in) begin
                        acc_q <= acc_q + w_sample_sext;
                        req_q <= 1'b0;
                        if (w_last) begin
                            state_q <= ST_SAT;
                        end else begin
                            idx_q   <= idx_q + VIDX_W'(1);
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_SAT: begin
                    mix_q   <= w_sat;
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    if (valid_q && mix_ready_in) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign unit_req_out   = req_q;
    assign unit_voice_out = idx_q;
    assign mix_valid_out  = valid_q;
    assign mix_data_out   = mix_q;
    assign busy_out       = busy_q;
    assign overrun_out    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_tone_voice_scheduler
// Brief  : Scoreboard bench for tone_voice_scheduler with a voice-unit model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tone_voice_scheduler;

    localparam int NV = 4;
    localparam int SW = 16;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic [NV-1:0] en;
    logic          ack;
    logic [SW-1:0] sample;
    logic          rdy;
    logic          clr;
    logic          unit_req_out;
    logic [VW-1:0] unit_voice_out;
    logic          mix_valid_out;
    logic [SW-1:0] mix_data_out;
    logic          busy_out;
    logic          overrun_out;

    int total = 0;
    int bad   = 0;

    logic [SW-1:0] tbl [NV];
    int            ack_wait;
    int            wait_cnt;
    logic [VW-1:0] held_voice;
    int            unstable;

    logic [SW-1:0] exp_mix[$];
    logic [SW-1:0] obs_mix[$];
    logic [VW-1:0] exp_voice[$];
    logic [VW-1:0] obs_voice[$];

    always #5 clk = ~clk;

    tone_voice_scheduler #(
        .NUM_VOICES (NV),
        .SAMPLE_W   (SW),
        .VIDX_W     (VW)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .frame_start_in   (frame_start),
        .voice_en_in      (en),
        .unit_req_out     (unit_req_out),
        .unit_voice_out   (unit_voice_out),
        .unit_ack_in      (ack),
        .unit_sample_in   (sample),
        .mix_valid_out    (mix_valid_out),
        .mix_data_out     (mix_data_out),
        .mix_ready_in     (rdy),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .clear_overrun_in (clr)
    );

    function automatic logic [SW-1:0] model_mix(input logic [NV-1:0] m);
        int s;
        s = 0;
        for (int v = 0; v < NV; v++) begin
            if (m[v]) s += $signed(tbl[v]);
        end
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    // One clock: log a handshake about to happen, then model the voice unit at negedge.
    task automatic cycle();
        if (mix_valid_out === 1'b1 && rdy === 1'b1) obs_mix.push_back(mix_data_out);
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0;
        if (unit_req_out === 1'b1) begin
            if (wait_cnt == 0) held_voice = unit_voice_out;
            else if (unit_voice_out !== held_voice) unstable++;
            if (wait_cnt >= ack_wait) begin
                ack    = 1'b1;
                sample = tbl[unit_voice_out];
                obs_voice.push_back(unit_voice_out);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic start_frame(input logic [NV-1:0] m);
        for (int v = 0; v < NV; v++) if (m[v]) exp_voice.push_back(VW'(v));
        exp_mix.push_back(model_mix(m));
        en          = m;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input logic [NV-1:0] m, output bit ok);
        int n0;
        n0 = obs_mix.size();
        start_frame(m);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            if (obs_mix.size() > n0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; en = '0; ack = 1'b0; sample = '0;
        rdy = 1'b1; clr = 1'b0; ack_wait = 0; wait_cnt = 0; unstable = 0;
        repeat (3) cycle();
        total++; if (unit_req_out !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", unit_req_out); end
        total++; if (mix_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", mix_valid_out); end
        total++; if (mix_data_out !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", mix_data_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        total++; if (overrun_out !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun_out); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_all_voices();
        bit ok;
        logic [SW-1:0] em;
        logic [VW-1:0] ev;
        logic [VW-1:0] ov;
        tbl[0] = 16'h0100; tbl[1] = 16'h0200; tbl[2] = 16'h0300; tbl[3] = 16'h0400;
        ack_wait = 0;
        run_frame(4'b1111, ok);
        total++; if (!ok) begin bad++; $display("FAIL all_voices_timeout: got no mix want one"); end
        total++; if (obs_voice.size() != exp_voice.size()) begin bad++; $display("FAIL all_voices_req_count: got %0d want %0d", obs_voice.size(), exp_voice.size()); end
        while (exp_voice.size() != 0 && obs_voice.size() != 0) begin
            ev = exp_voice.pop_front(); ov = obs_voice.pop_front();
            total++; if (ov !== ev) begin bad++; $display("FAIL all_voices_idx: got %0d want %0d", ov, ev); end
        end
        em = exp_mix.pop_front();
        total++; if (obs_mix.size() == 0 || obs_mix[0] !== em) begin bad++; $display("FAIL all_voices_mix: got %h want %h", (obs_mix.size() != 0) ? obs_mix[0] : 16'hxxxx, em); end
        total++; if (em !== 16'h0A00) begin bad++; $display("FAIL all_voices_model: got %h want 0a00", em); end
        exp_voice.delete(); obs_voice.delete(); obs_mix.delete();
    endtask

    task automatic test_sparse_wait();
        bit ok;
        logic [SW-1:0] em;
        logic [VW-1:0] ev;
        logic [VW-1:0] ov;
        tbl[0] = 16'h1000; tbl[1] = 16'h0777; tbl[2] = 16'h2000; tbl[3] = 16'h0555;
        ack_wait = 3; unstable = 0;
        run_frame(4'b0101, ok);
        total++; if (!ok) begin bad++; $display("FAIL sparse_timeout: got no mix want one"); end
        total++; if (obs_voice.size() != 2) begin bad++; $display("FAIL sparse_req_count: got %0d want 2", obs_voice.size()); end
        while (exp_voice.size() != 0 && obs_voice.size() != 0) begin
            ev = exp_voice.pop_front(); ov = obs_voice.pop_front();
            total++; if (ov !== ev) begin bad++; $display("FAIL sparse_idx: got %0d want %0d", ov, ev); end
        end
        em = exp_mix.pop_front();
        total++; if (obs_mix.size() == 0 || obs_mix[0] !== 16'h3000 || em !== 16'h3000) begin bad++; $display("FAIL sparse_mix: got %h want 3000", (obs_mix.size() != 0) ? obs_mix[0] : 16'hxxxx); end
        total++; if (unstable != 0) begin bad++; $display("FAIL sparse_req_stable: got %0d changes want 0", unstable); end
        exp_voice.delete(); obs_voice.delete(); obs_mix.delete();
        ack_wait = 0;
    endtask

    task automatic test_saturation();
        bit ok;
        logic [SW-1:0] em;
        for (int v = 0; v < NV; v++) tbl[v] = 16'h7000;
        run_frame(4'b1111, ok);
        em = exp_mix.pop_front();
        total++; if (!ok || obs_mix[0] !== em || em !== 16'h7FFF) begin bad++; $display("FAIL sat_pos: got %h want 7fff", ok ? obs_mix[0] : 16'hxxxx); end
        obs_mix.delete();
        for (int v = 0; v < NV; v++) tbl[v] = 16'h9000;
        run_frame(4'b1111, ok);
        em = exp_mix.pop_front();
        total++; if (!ok || obs_mix[0] !== em || em !== 16'h8000) begin bad++; $display("FAIL sat_neg: got %h want 8000", ok ? obs_mix[0] : 16'hxxxx); end
        obs_mix.delete(); exp_voice.delete(); obs_voice.delete();
        // Empty mask: pulse captured at edge 0, valid must appear exactly after edge 6.
        en = 4'b0000; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        repeat (5) cycle();
        total++; if (mix_valid_out !== 1'b0) begin bad++; $display("FAIL lat_edge5: got valid=%b want 0", mix_valid_out); end
        cycle();
        total++; if (mix_valid_out !== 1'b1 || mix_data_out !== 16'h0000) begin bad++; $display("FAIL lat_edge6: got valid=%b data=%h want 1/0000", mix_valid_out, mix_data_out); end
        cycle();
        total++; if (busy_out !== 1'b0 || obs_voice.size() != 0) begin bad++; $display("FAIL lat_done: got busy=%b reqs=%0d want 0/0", busy_out, obs_voice.size()); end
        obs_mix.delete();
    endtask

    task automatic test_backpressure();
        bit seen;
        int stab_bad;
        logic [SW-1:0] d0;
        logic [SW-1:0] em;
        for (int v = 0; v < NV; v++) tbl[v] = 16'h0010 + 16'(v);
        rdy = 1'b0;
        start_frame(4'b1111);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle();
            if (mix_valid_out === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_timeout: got no valid want valid"); end
        d0 = mix_data_out; stab_bad = 0;
        for (int i = 0; i < 10; i++) begin
            frame_start = (i == 3 || i == 6);
            clr         = (i == 6);
            cycle();
            frame_start = 1'b0; clr = 1'b0;
            if (mix_valid_out !== 1'b1 || mix_data_out !== d0) stab_bad++;
        end
        total++; if (stab_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_bad); end
        total++; if (overrun_out !== 1'b1) begin bad++; $display("FAIL bp_overrun_set: got %b want 1", overrun_out); end
        rdy = 1'b1;
        repeat (12) cycle();
        em = exp_mix.pop_front();
        total++; if (obs_mix.size() != 1 || obs_mix[0] !== em) begin bad++; $display("FAIL bp_single_mix: got %0d mixes want 1 of %h", obs_mix.size(), em); end
        total++; if (busy_out !== 1'b0 || overrun_out !== 1'b1) begin bad++; $display("FAIL bp_idle: got busy=%b ovr=%b want 0/1", busy_out, overrun_out); end
        clr = 1'b1; cycle(); clr = 1'b0;
        total++; if (overrun_out !== 1'b0) begin bad++; $display("FAIL bp_clear: got %b want 0", overrun_out); end
        obs_mix.delete(); exp_voice.delete(); obs_voice.delete();
        // Frame pulse coinciding with the completing handshake is still an overrun.
        rdy = 1'b0;
        start_frame(4'b0011);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle();
            if (mix_valid_out === 1'b1) seen = 1'b1;
        end
        rdy = 1'b1; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        total++; if (overrun_out !== 1'b1 || mix_valid_out !== 1'b0) begin bad++; $display("FAIL hs_overrun: got ovr=%b valid=%b want 1/0", overrun_out, mix_valid_out); end
        repeat (10) cycle();
        em = exp_mix.pop_front();
        total++; if (obs_mix.size() != 1 || obs_mix[0] !== em || busy_out !== 1'b0) begin bad++; $display("FAIL hs_single_mix: got %0d mixes busy=%b want 1/0", obs_mix.size(), busy_out); end
        clr = 1'b1; cycle(); clr = 1'b0;
        obs_mix.delete(); exp_voice.delete(); obs_voice.delete();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit ok;
        int vcount;
        logic [VW-1:0] ev;
        logic [VW-1:0] ov;
        logic [SW-1:0] em;
        for (int v = 0; v < NV; v++) tbl[v] = 16'h0100;
        ack_wait = 4; en = 4'b1111; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle();
            if (unit_req_out === 1'b1 && unit_voice_out === 2'd2) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_reach: got no req for voice 2 want req"); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        total++; if (unit_req_out !== 1'b0 || busy_out !== 1'b0 || mix_valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got req=%b busy=%b valid=%b want 0/0/0", unit_req_out, busy_out, mix_valid_out); end
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (mix_valid_out === 1'b1) vcount++;
        end
        total++; if (vcount != 0 || obs_mix.size() != 0) begin bad++; $display("FAIL rstmid_no_mix: got %0d valid cycles want 0", vcount); end
        obs_voice.delete();
        for (int v = 0; v < NV; v++) tbl[v] = 16'h0040 << v;
        ack_wait = 0;
        run_frame(4'b1111, ok);
        while (exp_voice.size() != 0 && obs_voice.size() != 0) begin
            ev = exp_voice.pop_front(); ov = obs_voice.pop_front();
            total++; if (ov !== ev) begin bad++; $display("FAIL rstmid_next_idx: got %0d want %0d", ov, ev); end
        end
        em = exp_mix.pop_front();
        total++; if (!ok || obs_mix[0] !== em) begin bad++; $display("FAIL rstmid_next_mix: got %h want %h", ok ? obs_mix[0] : 16'hxxxx, em); end
        obs_mix.delete(); exp_voice.delete(); obs_voice.delete();
    endtask

    task automatic test_mask_freeze();
        bit done;
        bit ok;
        logic [SW-1:0] em;
        tbl[0] = 16'h0011; tbl[1] = 16'h0022; tbl[2] = 16'h0033; tbl[3] = 16'h0044;
        ack_wait = 0;
        start_frame(4'b1111);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle();
            if (obs_voice.size() == 1 && unit_req_out === 1'b0 && busy_out === 1'b1) en = 4'b0001;
            if (obs_mix.size() != 0) done = 1'b1;
        end
        em = exp_mix.pop_front();
        total++; if (obs_voice.size() != 4) begin bad++; $display("FAIL freeze_cur_reqs: got %0d want 4", obs_voice.size()); end
        total++; if (!done || obs_mix[0] !== em) begin bad++; $display("FAIL freeze_cur_mix: got %h want %h", done ? obs_mix[0] : 16'hxxxx, em); end
        obs_mix.delete(); obs_voice.delete(); exp_voice.delete();
        run_frame(4'b0001, ok);
        em = exp_mix.pop_front();
        total++; if (obs_voice.size() != 1) begin bad++; $display("FAIL freeze_next_reqs: got %0d want 1", obs_voice.size()); end
        total++; if (!ok || obs_mix[0] !== em || em !== 16'h0011) begin bad++; $display("FAIL freeze_next_mix: got %h want 0011", ok ? obs_mix[0] : 16'hxxxx); end
        obs_mix.delete(); obs_voice.delete(); exp_voice.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_voices();
        test_sparse_wait();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_mask_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
